// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher datapath: state type, GF(2^8)
// helpers, the inverse S-box and byte addressing within the 128-bit state.
package aes_pkg;

    localparam int NR = 14;

    typedef logic [127:0] state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse affine map followed by the field inverse computed as x^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b, x2, x3, x12, x15, x240;
        b    = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        x2   = gmul(b, b);
        x3   = gmul(x2, b);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        return gmul(gmul(x240, x12), x2);
    endfunction

    // Bit position of the MSB of byte s[r][c]; bytes are column-major from bit 127.
    function automatic int byte_pos(input int r, input int c);
        return 127 - 8 * (4 * c + r);
    endfunction

    function automatic logic [7:0] inv_mix_coef(input int k);
        case (k)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

endpackage

// File: rtl/decrypt_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module decrypt_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    state_t ark;
    state_t mixed;

    always_comb begin
        ark   = '0;
        mixed = '0;
        // Row r rotates right by r, so s'[r][c] comes from column (c - r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[byte_pos(r, c) -: 8] = inv_sbox(state_i[byte_pos(r, (c + 4 - r) % 4) -: 8])
                                         ^ round_key_i[byte_pos(r, c) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < 4; k++) begin
                    mixed[byte_pos(r, c) -: 8] ^= gmul(inv_mix_coef((k + 4 - r) % 4),
                                                       ark[byte_pos(k, c) -: 8]);
                end
            end
        end
    end

    assign state_o = last_i ? ark : mixed;

endmodule

// File: rtl/aes256_decrypt_core.sv
// Iterative AES-256 inverse cipher: whitening on accept, then one inverse round per
// clock from rk[13] down to rk[0], result held until the sink takes it.
module aes256_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rk_we,
    input  logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] fsm_q, fsm_d;
    logic [3:0] rnd_q, rnd_d;
    state_t     state_q, state_d;
    state_t     rk_q [0:NR];
    state_t     round_out;

    decrypt_round u_round (
        .state_i     (state_q),
        .round_key_i (rk_q[rnd_q]),
        .last_i      (rnd_q == 4'd0),
        .state_o     (round_out)
    );

    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign out_data  = out_valid ? state_q : '0;

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ rk_q[NR];
                    rnd_d   = 4'(NR - 1);
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                state_d = round_out;
                if (rnd_q == 4'd0) fsm_d = S_DONE;
                else               rnd_d = rnd_q - 4'd1;
            end
            S_DONE: begin
                if (out_ready) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
            rnd_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            rnd_q <= rnd_d;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Keys only change while idle; an accept on the same edge already read the old rk[14].
    always_ff @(posedge clk) begin
        if (rk_we && fsm_q == S_IDLE && rk_idx < 4'(NR + 1)) begin
            rk_q[rk_idx] <= rk_data;
        end
    end

endmodule

// File: tb/tb_aes256_decrypt_core.sv
// Bench for aes256_decrypt_core: keys come from a behavioural key expansion and
// ciphertexts from a forward-cipher model, so every decrypt must return the plaintext.
module tb_aes256_decrypt_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rk_we;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int checks;
    int errors;

    logic [7:0]   sbox [256];
    logic [127:0] mrk  [15];

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes256_decrypt_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rk_we     (rk_we),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        for (int r = 0; r < 15; r++) mrk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Forward cipher on a byte array indexed 4*col+row.
    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = pt ^ mrk[0];
        for (int rd = 1; rd <= 14; rd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[v[127 - 8 * k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
            if (rd < 14) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gf_mul(2, t[4*c]) ^ gf_mul(3, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gf_mul(2, t[4*c+1]) ^ gf_mul(3, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(2, t[4*c+2]) ^ gf_mul(3, t[4*c+3]);
                    s[4*c+3] = gf_mul(3, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(2, t[4*c+3]);
                end
            end else begin
                s = t;
            end
            for (int k = 0; k < 16; k++) v[127 - 8 * k -: 8] = s[k];
            v ^= mrk[rd];
        end
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys();
        for (int i = 0; i < 15; i++) begin
            rk_we = 1'b1; rk_idx = 4'(i); rk_data = mrk[i];
            tick();
        end
        rk_we = 1'b0;
    endtask

    task automatic new_random_key();
        expand_key({rand128(), rand128()});
        load_keys();
    endtask

    // lat counts edges from the accepting edge (inclusive) to the one raising out_valid.
    task automatic run_block(input logic [127:0] ct, input bit finish,
                             output logic [127:0] got, output int lat, output bit ok);
        int n;
        ok = 1'b1; n = 0;
        in_data = ct; in_valid = 1'b1;
        while (!in_ready && n < 100) begin tick(); n++; end
        if (!in_ready) ok = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin tick(); lat++; end
        if (!out_valid) ok = 1'b0;
        got = out_data;
        if (finish) begin
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fips_vector();
        logic [127:0] got;
        int lat;
        bit ok;
        expand_key(FIPS_KEY);
        load_keys();
        run_block(FIPS_CT, 1'b1, got, lat, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fips_timeout got timeout want handshake"); end
        checks++;
        if (got !== FIPS_PT) begin errors++; $display("FAIL fips_data got %h want %h", got, FIPS_PT); end
        checks++;
        if (lat !== 15) begin errors++; $display("FAIL fips_latency got %0d want 15", lat); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_illegal_index();
        logic [127:0] got;
        int lat;
        bit ok;
        rk_we = 1'b1; rk_idx = 4'd15; rk_data = rand128();
        tick();
        rk_we = 1'b0;
        run_block(FIPS_CT, 1'b1, got, lat, ok);
        checks++;
        if (!ok || got !== FIPS_PT) begin
            errors++; $display("FAIL illegal_idx got %h ok=%0d want %h", got, ok, FIPS_PT);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, got;
        int lat;
        bit ok;
        new_random_key();
        pt = rand128();
        run_block(aes_enc(pt), 1'b0, got, lat, ok);
        checks++;
        if (!ok || got !== pt) begin errors++; $display("FAIL bp_first got %h ok=%0d want %h", got, ok, pt); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_data !== pt || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got data=%h rdy=%b vld=%b want data=%h rdy=0 vld=1",
                         i, out_data, in_ready, out_valid, pt);
            end
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_key_lockout();
        logic [127:0] pt, got;
        int lat, n;
        bit ok;
        new_random_key();
        pt = rand128();
        in_data = aes_enc(pt); in_valid = 1'b1; n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rk_we = 1'b1; rk_idx = 4'd5; rk_data = '0;
        tick();
        rk_we = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        checks++;
        if (out_valid !== 1'b1 || out_data !== pt) begin
            errors++; $display("FAIL lockout_current got %h vld=%b want %h", out_data, out_valid, pt);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        pt = rand128();
        run_block(aes_enc(pt), 1'b1, got, lat, ok);
        checks++;
        if (!ok || got !== pt) begin errors++; $display("FAIL lockout_next got %h ok=%0d want %h", got, ok, pt); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt, got;
        int lat, n;
        bit ok;
        new_random_key();
        pt = rand128();
        in_data = aes_enc(pt); in_valid = 1'b1; n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0) begin
            errors++;
            $display("FAIL rst_mid got rdy=%b vld=%b data=%h want rdy=1 vld=0 data=0", in_ready, out_valid, out_data);
        end
        rst_n = 1'b1;
        pt = rand128();
        run_block(aes_enc(pt), 1'b1, got, lat, ok);
        checks++;
        if (!ok || got !== pt) begin errors++; $display("FAIL rst_mid_after got %h ok=%0d want %h", got, ok, pt); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q [$];
        logic [127:0] d_pt, m_exp;
        int d_n, m_guard, recv;
        for (int g = 0; g < 25; g++) begin
            new_random_key();
            recv = 0;
            fork
                begin
                    for (int b = 0; b < 8; b++) begin
                        repeat ($urandom_range(0, 3)) tick();
                        d_pt = rand128();
                        in_data = aes_enc(d_pt); in_valid = 1'b1; d_n = 0;
                        while (!in_ready && d_n < 200) begin tick(); d_n++; end
                        if (in_ready) exp_q.push_back(d_pt);
                        tick();
                        in_valid = 1'b0;
                    end
                end
                begin
                    m_guard = 0;
                    while (recv < 8 && m_guard < 800) begin
                        out_ready = ($urandom_range(0, 3) != 0);
                        if (out_valid && out_ready) begin
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++; $display("FAIL b2b_extra got %h want no output", out_data);
                            end else begin
                                m_exp = exp_q.pop_front();
                                if (out_data !== m_exp) begin
                                    errors++; $display("FAIL b2b_data got %h want %h", out_data, m_exp);
                                end
                            end
                            recv++;
                        end
                        tick();
                        m_guard++;
                    end
                    out_ready = 1'b0;
                end
            join
            checks++;
            if (recv != 8 || exp_q.size() != 0) begin
                errors++; $display("FAIL b2b_count group %0d got %0d outputs pending %0d want 8 pending 0",
                                   g, recv, exp_q.size());
            end
            exp_q.delete();
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; rk_we = 1'b0; rk_idx = '0; rk_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        build_sbox();
        test_reset();
        test_fips_vector();
        test_illegal_index();
        test_backpressure();
        test_key_lockout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes256_decrypt_core.md
# aes256_decrypt_core

Iterative AES-256 inverse cipher: decrypts one 128-bit ciphertext block per transaction, one inverse round per clock, using the 15 round keys held in an internal register file. It is the receive-side counterpart of the combinational forward round datapath, and sits behind the key-expansion unit, which writes the round keys. It exposes valid/ready streams on input and output for the GCM wrapper and test harnesses.

## Interface
- NR, 14, number of rounds; fixed for AES-256. Other values are unsupported.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- rk_we  in  1  round-key write strobe.
- rk_idx  in  4  round-key index, 0..14. Indices 15 and up are ignored.
- rk_data  in  128  round key w[4i..4i+3] of the encryption key schedule.
- in_valid  in  1  ciphertext is valid.
- in_ready  out  1  core can accept a block.
- in_data  in  128  ciphertext. Bits [127:120] are byte s0,0; bytes are in FIPS-197 column-major order.
- out_valid  out  1  plaintext is valid.
- out_ready  in  1  sink accepts the plaintext.
- out_data  out  128  plaintext, with the same byte order as in_data.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&in_ready, the core registers state <= in_data ^ rk[14], sets rnd <= 13, and moves to RUN.
- RUN, with rnd >= 1: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[rnd])), then rnd <= rnd-1.
- RUN, with rnd == 0 (final round): state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]) with no InvMixColumns. The core then moves to DONE.
- DONE: out_valid=1 and out_data=state. Both are held stable until out_valid&out_ready, then the core returns to IDLE.
- Round-key writes: accepted only in IDLE. A write in RUN or DONE is dropped, so keys cannot change mid-block. A write in IDLE that coincides with an input handshake takes effect after the rk[14] read. The first round uses the old rk[14].
- The round-key file is not reset. Contents are undefined until written.
- GF(2^8) arithmetic uses the polynomial x^8+x^4+x^3+x+1. InvMixColumns uses the coefficients {0e,0b,0d,09}.
- rnd is 4 bits. It never wraps: the final round is detected at rnd==0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, state=IDLE, rnd=0.
- Latency: out_valid rises 15 clock edges after the accepting edge: 1 edge for the whitening load, 13 middle rounds, and 1 final round. No extra edge is spent entering DONE.
- Throughput: one block per 16 cycles with out_ready tied high. in_ready rises on the cycle after the output handshake. There is no overlap.
- in_ready is a function of state only. It does not depend on in_valid.
- out_ready low in DONE stalls indefinitely with no data change.
- rst_n low in any state returns the core to IDLE with the reset values on the next edge. An in-flight block is discarded. Round keys are kept.

## Structure
- Shared package aes_pkg holds:
  - NR and the 128-bit state typedef
  - the inverse S-box function
  - the xtime and gmul helpers
  - byte/column index helpers
- Sub-module decrypt_round: combinational, with inputs state, round_key, and a last flag that bypasses InvMixColumns. It is instantiated once and iterated by the FSM.
- The FSM, rnd counter, round-key register file (15×128) and handshakes live in the top module.

## Test plan
- FIPS-197 C.3 vector:
  - Stimulus: write rk[0..14] from a model expansion of key 000102…1f, then send ct 8ea2b7ca516745bfeafc49904b496089.
  - Response: out_data = 00112233445566778899aabbccddeeff, with out_valid exactly 15 edges after the accepting edge.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles in DONE.
  - Response: out_data stays stable and in_ready=0 throughout. Handshake on release, then in_ready=1 on the next cycle.
- Key-write lockout:
  - Stimulus: write rk[5]=0 during RUN.
  - Response: the current and the next decryptions are both still correct against the model.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at round 7 for one cycle.
  - Response: the next cycle shows in_ready=1, out_valid=0, out_data=0. A following decrypt is correct without reloading keys.
- Back-to-back random:
  - Stimulus: 200 random key/ciphertext pairs with random in_valid/out_ready gaps.
  - Response: every out_data matches the reference model, and no transaction is lost or duplicated.
- Illegal index:
  - Stimulus: write with rk_idx=15.
  - Response: no round key changes, and the vector from the first scenario still passes.
